// File: rtl/regfile_psr_stage.sv
// Operand-fetch / writeback stage around the combinational ALU: register file,
// PSR, registered ALU operands with writeback bypass, and debug read port.
module regfile_psr_stage #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [3:0]        opcode,
  input  logic [3:0]        opext,
  input  logic [3:0]        rdest,
  input  logic [3:0]        rsrc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] alu_s,
  input  logic [4:0]        alu_flags,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [7:0]        op_out,
  output logic              carry_in,
  output logic              ex_valid,
  output logic [4:0]        psr,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [3:0]        rdest_p1;
  logic              wb_p1;
  logic [DATA_W-1:0] a_nxt_p0;
  logic [DATA_W-1:0] b_nxt_p0;

  function automatic logic op_writes(input logic [7:0] op);
    logic w;
    w = 1'b0;
    case (op[7:4])
      4'b0101, 4'b0110, 4'b0111: w = 1'b1;
      4'b0000: w = (op[3:0] == 4'b0001) || (op[3:0] == 4'b0101) ||
                   (op[3:0] == 4'b0110) || (op[3:0] == 4'b0111);
      4'b1010: w = (op[3:0] == 4'b0101) || (op[3:0] == 4'b0110);
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic op_has_imm(input logic [3:0] opc);
    return (opc == 4'b0101) || (opc == 4'b0110) || (opc == 4'b0111);
  endfunction

  // ADDUI zero-extends; ADDI and ADDCI sign-extend.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [3:0] opc,
                                                input logic [IMM_W-1:0] im);
    logic signed [IMM_W-1:0]  sim;
    logic signed [DATA_W-1:0] sext;
    sim  = im;
    sext = DATA_W'(sim);
    if (opc == 4'b0110)
      return {{(DATA_W-IMM_W){1'b0}}, im};
    return sext;
  endfunction

  // ---- p0: operand fetch with bypass from the instruction writing back this edge
  assign wb_p1 = ex_valid && op_writes(op_out);

  always_comb begin
    a_nxt_p0 = regs[rdest];
    if (wb_p1 && (rdest_p1 == rdest))
      a_nxt_p0 = alu_s;
    if (op_has_imm(opcode))
      b_nxt_p0 = ext_imm(opcode, imm);
    else if (wb_p1 && (rdest_p1 == rsrc))
      b_nxt_p0 = alu_s;
    else
      b_nxt_p0 = regs[rsrc];
  end

  // ---- p1: EX-stage registers, register-file writeback and PSR capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      psr      <= '0;
      a_out    <= '0;
      b_out    <= '0;
      op_out   <= '0;
      ex_valid <= 1'b0;
      rdest_p1 <= '0;
    end else begin
      if (wb_p1) begin
        regs[rdest_p1] <= alu_s;
        psr            <= alu_flags;
      end
      ex_valid <= instr_valid;
      if (instr_valid) begin
        op_out   <= {opcode, opext};
        a_out    <= a_nxt_p0;
        b_out    <= b_nxt_p0;
        rdest_p1 <= rdest;
      end
    end
  end

  assign carry_in = psr[4];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_psr_stage.sv
// Scoreboard bench for regfile_psr_stage: a behavioural register-file model
// predicts each cycle's outputs; a monitor pops and compares after each edge.
module tb_regfile_psr_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [3:0]  opcode, opext, rdest, rsrc, dbg_addr;
  logic [7:0]  imm;
  logic [15:0] alu_s;
  logic [4:0]  alu_flags;
  logic [15:0] a_out, b_out, dbg_data;
  logic [7:0]  op_out;
  logic        carry_in, ex_valid;
  logic [4:0]  psr;

  regfile_psr_stage #(.NUM_REGS(16), .DATA_W(16), .IMM_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .opext(opext), .rdest(rdest), .rsrc(rsrc), .imm(imm), .alu_s(alu_s),
    .alu_flags(alu_flags), .a_out(a_out), .b_out(b_out), .op_out(op_out),
    .carry_in(carry_in), .ex_valid(ex_valid), .psr(psr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [15:0] a, b;
    logic [7:0]  op;
    logic [4:0]  p;
    logic [15:0] dbg;
    string       tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference state
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;
  logic        m_ev;
  logic [7:0]  m_op;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_rd;

  function automatic logic writes_back(input logic [7:0] op);
    logic [7:0] codes [9] = '{8'h01, 8'h05, 8'h06, 8'h07, 8'hA5, 8'hA6,
                              8'h50, 8'h60, 8'h70};
    if (op[7:4] == 4'h5 || op[7:4] == 4'h6 || op[7:4] == 4'h7) return 1'b1;
    for (int i = 0; i < 6; i++)
      if (codes[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input string tag,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s [%s] got=%0h expected=%0h at %0t", name, tag, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ex_valid", e.tag, 32'(ex_valid), 32'(e.ev));
      chk("psr",      e.tag, 32'(psr),      32'(e.p));
      chk("carry_in", e.tag, 32'(carry_in), 32'(e.p[4]));
      chk("dbg_data", e.tag, 32'(dbg_data), 32'(e.dbg));
      chk("a_out",    e.tag, 32'(a_out),    32'(e.a));
      chk("b_out",    e.tag, 32'(b_out),    32'(e.b));
      chk("op_out",   e.tag, 32'(op_out),   32'(e.op));
    end
  end

  // Drive one cycle (called just after a falling edge) and predict its outcome.
  task automatic step(input logic rst, input logic v, input logic [3:0] opc,
                      input logic [3:0] ext, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [7:0] im,
                      input logic [15:0] s, input logic [4:0] fl,
                      input logic [3:0] da, input string tag);
    exp_t e;
    reset = rst; instr_valid = v; opcode = opc; opext = ext; rdest = rd;
    rsrc = rs; imm = im; alu_s = s; alu_flags = fl; dbg_addr = da;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_psr = 5'h0; m_ev = 1'b0; m_op = 8'h0; m_a = 16'h0; m_b = 16'h0;
    end else begin
      if (m_ev && writes_back(m_op)) begin
        m_regs[m_rd] = s;
        m_psr = fl;
      end
      m_ev = v;
      if (v) begin
        m_op = {opc, ext};
        m_rd = rd;
        m_a  = m_regs[rd];
        if (opc == 4'h6)                     m_b = {8'h00, im};
        else if (opc == 4'h5 || opc == 4'h7) m_b = {{8{im[7]}}, im};
        else                                 m_b = m_regs[rs];
      end
    end
    e.ev = m_ev; e.a = m_a; e.b = m_b; e.op = m_op; e.p = m_psr;
    e.dbg = m_regs[da]; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_step(input string tag);
    logic [3:0] opc, ext;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: begin opc = 4'h0; ext = 4'h1; end
      1: begin opc = 4'h0; ext = 4'h5; end
      2: begin opc = 4'h0; ext = 4'h6; end
      3: begin opc = 4'h0; ext = 4'h7; end
      4: begin opc = 4'hA; ext = 4'(5 + $urandom_range(0, 1)); end
      5: begin opc = 4'(5 + $urandom_range(0, 2)); ext = 4'($urandom); end
      default: begin opc = 4'($urandom); ext = 4'($urandom); end
    endcase
    step(1'b0, ($urandom_range(0, 4) != 0), opc, ext,
         4'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 3)),
         4'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 3)),
         8'($urandom), 16'($urandom), 5'($urandom), 4'($urandom_range(0, 3)), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired with %0d pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; opext = '0; rdest = '0;
    rsrc = '0; imm = '0; alu_s = '0; alu_flags = '0; dbg_addr = '0;
    @(negedge clk);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    // Load some state, then reset with an instruction in EX
    step(0, 1, 4'h6, 4'h0, 4'h7, 4'h0, 8'h33, 16'h0, 5'h0, 4'h7, "pre_rst_a");
    step(0, 1, 4'h6, 4'h0, 4'h8, 4'h0, 8'h44, 16'h1234, 5'h1F, 4'h7, "pre_rst_b");
    step(1, 0, 0, 0, 0, 0, 0, 16'hBEEF, 5'h1F, 4'h8, "mid_rst");
    for (int i = 0; i < 16; i++)
      step(0, 0, 0, 0, 0, 0, 0, 16'hDEAD, 5'h1F, 4'(i), "post_rst_regs");
    // ADDI sign-extension, ADDUI zero-extension with PSR capture
    step(0, 1, 4'h5, 4'h0, 4'h1, 4'h0, 8'hFF, 16'h0, 5'h0, 4'h1, "addi_issue");
    step(0, 1, 4'h6, 4'h0, 4'h2, 4'h0, 8'h80, 16'hFFFF, 5'h00, 4'h1, "addui_issue");
    step(0, 1, 4'h7, 4'h0, 4'h5, 4'h0, 8'h7F, 16'h0080, 5'b10010, 4'h2, "addci_issue");
    // Back-to-back dependency through the bypass (A and B, rdest==rsrc)
    step(0, 1, 4'h6, 4'h0, 4'h3, 4'h0, 8'h05, 16'h1111, 5'h03, 4'h3, "b2b_1");
    step(0, 1, 4'h0, 4'h5, 4'h4, 4'h3, 8'h00, 16'h0005, 5'h04, 4'h3, "b2b_2");
    step(0, 1, 4'h0, 4'h5, 4'h4, 4'h4, 8'h00, 16'h000A, 5'h08, 4'h4, "b2b_same");
    // Undefined op leaves registers and PSR untouched
    step(0, 1, 4'hF, 4'hF, 4'h4, 4'h4, 8'h00, 16'h0014, 5'h01, 4'h4, "undef_issue");
    step(0, 0, 0, 0, 0, 0, 0, 16'h9999, 5'h1F, 4'h4, "undef_wb");
    // Carry set by ADDU, then visible throughout ADDC
    step(0, 1, 4'h0, 4'h6, 4'h6, 4'h1, 8'h00, 16'h0, 5'h00, 4'h6, "addu");
    step(0, 1, 4'h0, 4'h7, 4'h6, 4'h1, 8'h00, 16'h0001, 5'b10000, 4'h6, "addc");
    step(0, 0, 0, 0, 0, 0, 0, 16'h0002, 5'b00001, 4'h6, "addc_wb");
    for (int i = 0; i < 1500; i++) rand_step("random");
    step(1, 1, 4'h5, 4'h0, 4'h2, 4'h0, 8'h12, 16'hAAAA, 5'h1F, 4'h2, "rand_rst");
    for (int i = 0; i < 500; i++) rand_step("random2");
    step(0, 0, 0, 0, 0, 0, 0, 16'h0, 5'h0, 4'h0, "drain");
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
